// File: rtl/axis_frame_ingress.sv
// axis_frame_ingress
//   AXI4-Stream video ingress. Frames camera beats by SOF (tuser) and EOL
//   (tlast), checks line/frame geometry against IMG_W/IMG_H, and forwards
//   beats through a 2-entry skid buffer tagged with counter-derived sof/eol.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   s_axis_*             upstream stream (tready is registered)
//   frame_type_i         frame type, sampled on the SOF beat
//   dout/dout_vld/dout_rdy, dout_sof, dout_eol   local output stream
//   frame_start          1-cycle pulse per accepted SOF
//   frame_type_o         type latched at the last SOF
//   frame_cnt            accepted SOF count (wraps)
//   err_early_eol, err_missing_eol, err_short_frame, err_orphan   1-cycle pulses
//   err_sticky           {orphan, short_frame, missing_eol, early_eol}
//   err_clr              clears err_sticky (a same-cycle pulse still sets)
module axis_frame_ingress #(
  parameter int DATA_W      = 64,
  parameter int PIX_W       = 8,
  parameter int IMG_W       = 2048,
  parameter int IMG_H       = 2048,
  parameter int DROP_ORPHAN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic [1:0]        frame_type_i,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              dout_sof,
  output logic              dout_eol,
  output logic              frame_start,
  output logic [1:0]        frame_type_o,
  output logic [15:0]       frame_cnt,
  output logic              err_early_eol,
  output logic              err_missing_eol,
  output logic              err_short_frame,
  output logic              err_orphan,
  output logic [3:0]        err_sticky,
  input  logic              err_clr
);

  localparam int BPL  = IMG_W * PIX_W / DATA_W;
  localparam int BC_W = (BPL > 1)   ? $clog2(BPL)   : 1;
  localparam int LC_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPL - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(IMG_H - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t          state;
  logic [BC_W-1:0] beat_cnt;
  logic [LC_W-1:0] line_cnt;

  // ---------------- beat classification ----------------
  logic            accept, in_frame, at_last, line_end, push, pop;
  logic [BC_W-1:0] bc_eff;
  logic [LC_W-1:0] lc_eff;
  beat_t           in_beat;

  always_comb begin
    accept   = s_axis_tvalid & s_axis_tready;
    // A SOF restarts geometry, so its checks run against beat 0 / line 0.
    bc_eff   = s_axis_tuser ? '0 : beat_cnt;
    lc_eff   = s_axis_tuser ? '0 : line_cnt;
    in_frame = s_axis_tuser | (state == ACTIVE);
    at_last  = (bc_eff == BC_LAST);
    line_end = in_frame & (s_axis_tlast | at_last);
    push     = accept & (in_frame | (DROP_ORPHAN == 0));
    pop      = dout_vld & dout_rdy;
    in_beat.sof  = s_axis_tuser;
    in_beat.eol  = line_end;
    in_beat.data = s_axis_tdata;
  end

  // ---------------- framing FSM + status ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      line_cnt        <= '0;
      frame_start     <= 1'b0;
      frame_type_o    <= 2'b00;
      frame_cnt       <= 16'd0;
      err_early_eol   <= 1'b0;
      err_missing_eol <= 1'b0;
      err_short_frame <= 1'b0;
      err_orphan      <= 1'b0;
      err_sticky      <= 4'b0000;
    end else begin
      frame_start     <= 1'b0;
      err_early_eol   <= 1'b0;
      err_missing_eol <= 1'b0;
      err_short_frame <= 1'b0;
      err_orphan      <= 1'b0;
      // Sticky sees the registered pulses, so set beats a same-cycle clear.
      err_sticky <= (err_clr ? 4'b0000 : err_sticky)
                  | {err_orphan, err_short_frame, err_missing_eol, err_early_eol};
      if (accept) begin
        if (s_axis_tuser) begin
          frame_start     <= 1'b1;
          frame_type_o    <= frame_type_i;
          frame_cnt       <= frame_cnt + 16'd1;
          err_short_frame <= (state == ACTIVE);
        end
        if (!in_frame) begin
          err_orphan <= 1'b1;
        end else begin
          err_early_eol   <= s_axis_tlast & ~at_last;
          err_missing_eol <= at_last & ~s_axis_tlast;
          if (line_end) begin
            beat_cnt <= '0;
            if (lc_eff == LC_LAST) begin
              state    <= IDLE;
              line_cnt <= '0;
            end else begin
              state    <= ACTIVE;
              line_cnt <= lc_eff + 1'b1;
            end
          end else begin
            state    <= ACTIVE;
            beat_cnt <= bc_eff + 1'b1;
            line_cnt <= lc_eff;
          end
        end
      end
    end
  end

  // ---------------- 2-entry skid buffer ----------------
  beat_t      mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] occ, occ_nxt;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 2'd1;
    else if (!push && pop) occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]        <= '0;
      mem[1]        <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      s_axis_tready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ_nxt;
      // tready only when a free slot is guaranteed for the next cycle.
      s_axis_tready <= (occ_nxt < 2'd2);
    end
  end

  assign dout_vld = (occ != 2'd0);
  assign dout     = mem[rd_ptr].data;
  assign dout_sof = mem[rd_ptr].sof;
  assign dout_eol = mem[rd_ptr].eol;

endmodule

// File: tb/tb_axis_frame_ingress.sv
// Directed bench for axis_frame_ingress, IMG_W=32, IMG_H=3, BPL=4.
// dut  : DROP_ORPHAN=1, main device under test.
// dut2 : DROP_ORPHAN=0, valid gated by en2, always ready; orphan forwarding.
module tb_axis_frame_ingress;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [1:0]  ftype = 2'b00;
  logic        dout_rdy = 1'b1, err_clr = 1'b0, en2 = 1'b0, rdy2 = 1'b1, v2;

  logic        tready, dout_vld, dout_sof, dout_eol, frame_start;
  logic [63:0] dout;
  logic [1:0]  ftype_o;
  logic [15:0] frame_cnt;
  logic        e_early, e_miss, e_short, e_orph;
  logic [3:0]  sticky;

  logic        t2, d2_vld, d2_sof, d2_eol, d2_fs, d2_early, d2_miss, d2_short, d2_orph;
  logic [63:0] d2_dout;
  logic [1:0]  d2_ft;
  logic [15:0] d2_fc;
  logic [3:0]  d2_sticky;

  always #5 clk = ~clk;
  assign v2 = tvalid & en2;

  axis_frame_ingress #(.DATA_W(64), .PIX_W(8), .IMG_W(32), .IMG_H(3), .DROP_ORPHAN(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .frame_type_i(ftype), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_sof(dout_sof), .dout_eol(dout_eol), .frame_start(frame_start),
    .frame_type_o(ftype_o), .frame_cnt(frame_cnt), .err_early_eol(e_early),
    .err_missing_eol(e_miss), .err_short_frame(e_short), .err_orphan(e_orph),
    .err_sticky(sticky), .err_clr(err_clr));

  axis_frame_ingress #(.DATA_W(64), .PIX_W(8), .IMG_W(32), .IMG_H(3), .DROP_ORPHAN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(v2),
    .s_axis_tready(t2), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .frame_type_i(ftype), .dout(d2_dout), .dout_vld(d2_vld), .dout_rdy(rdy2),
    .dout_sof(d2_sof), .dout_eol(d2_eol), .frame_start(d2_fs),
    .frame_type_o(d2_ft), .frame_cnt(d2_fc), .err_early_eol(d2_early),
    .err_missing_eol(d2_miss), .err_short_frame(d2_short), .err_orphan(d2_orph),
    .err_sticky(d2_sticky), .err_clr(err_clr));

  int errors = 0, checks = 0;
  logic [65:0] q1[$], q2[$];
  int n_fs = 0, n_early = 0, n_miss = 0, n_short = 0, n_orph = 0, n_orph2 = 0;
  int n_vld = 0, n_stall = 0;

  // Output/pulse monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (dout_vld && dout_rdy) q1.push_back({dout_sof, dout_eol, dout});
    if (d2_vld && rdy2)       q2.push_back({d2_sof, d2_eol, d2_dout});
    n_fs    <= n_fs    + int'(frame_start);
    n_early <= n_early + int'(e_early);
    n_miss  <= n_miss  + int'(e_miss);
    n_short <= n_short + int'(e_short);
    n_orph  <= n_orph  + int'(e_orph);
    n_orph2 <= n_orph2 + int'(d2_orph);
    n_vld   <= n_vld   + int'(dout_vld);
    n_stall <= n_stall + int'(tvalid && !tready && rst_n);
  end

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input logic [63:0] d, input logic u, input logic l, input logic [1:0] ft);
    bit acc = 1'b0;
    int n = 0;
    tdata = d; tuser = u; tlast = l; ftype = ft; tvalid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
      n++;
    end
    chk("accept", 66'(acc), 66'd1);
  endtask

  task automatic reset_chk(input string tag);
    @(negedge clk);
    chk(tag, 66'({tready, dout_vld, dout_sof, dout_eol, frame_start, ftype_o, frame_cnt,
                  e_early, e_miss, e_short, e_orph, sticky}), 66'd0);
    chk({tag, "_dout"}, 66'(dout), 66'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, b_fs, b_e, b_m, b_sh, b_o, b_o2, b_v, b_st, k;
    logic [3:0] pat;
    bit sdone;
    pat = 4'b1001;
    sdone = 1'b0;

    // ---- reset state ----
    tick(2);
    reset_chk("reset");
    realign();
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_first", 66'(tready), 66'd0);
    realign();
    @(negedge clk);
    chk("tready_rise", 66'(tready), 66'd1);
    realign();

    // ---- 1: clean frame ----
    s = q1.size(); b_fs = n_fs; b_e = n_early + n_miss + n_short + n_orph;
    send(64'h1000, 1'b1, 1'b0, 2'b01);
    idle();
    @(negedge clk);
    chk("s1_latency", 66'({dout_vld, dout_sof, dout_eol, frame_start}), 66'b1101);
    chk("s1_first_data", 66'(dout), 66'h1000);
    realign();
    for (int i = 1; i < 12; i++) send(64'h1000 + 64'(i), 1'b0, (i % 4) == 3, 2'b01);
    idle();
    tick(4);
    chk("s1_count", 66'(q1.size() - s), 66'd12);
    for (int i = 0; i < 12; i++)
      if (s + i < q1.size())
        chk("s1_beat", q1[s + i], {i == 0, (i % 4) == 3, 64'h1000 + 64'(i)});
    chk("s1_frame_cnt", 66'(frame_cnt), 66'd1);
    chk("s1_fs", 66'(n_fs - b_fs), 66'd1);
    chk("s1_no_err", 66'(n_early + n_miss + n_short + n_orph - b_e), 66'd0);

    // ---- 2: same frame under backpressure ----
    s = q1.size(); b_st = n_stall; b_e = n_early + n_miss + n_short + n_orph;
    fork
      begin
        for (int i = 0; i < 12; i++) send(64'h2000 + 64'(i), i == 0, (i % 4) == 3, 2'b01);
        idle();
        sdone = 1'b1;
      end
      begin
        k = 0;
        while (!sdone && k < 300) begin
          dout_rdy = pat[k % 4];
          realign();
          k++;
        end
        dout_rdy = 1'b1;
      end
    join
    tick(5);
    chk("s2_count", 66'(q1.size() - s), 66'd12);
    for (int i = 0; i < 12; i++)
      if (s + i < q1.size())
        chk("s2_beat", q1[s + i], {i == 0, (i % 4) == 3, 64'h2000 + 64'(i)});
    chk("s2_tready_drop", 66'(n_stall > b_st), 66'd1);
    chk("s2_frame_cnt", 66'(frame_cnt), 66'd2);
    chk("s2_no_err", 66'(n_early + n_miss + n_short + n_orph - b_e), 66'd0);

    // ---- 3: early and missing EOL ----
    s = q1.size(); b_e = n_early; b_m = n_miss; b_sh = n_short; b_o = n_orph;
    send(64'h3000, 1'b1, 1'b0, 2'b01);
    send(64'h3001, 1'b0, 1'b1, 2'b01);
    idle();
    @(negedge clk);
    chk("s3_early_pulse", 66'({e_early, dout_vld, dout_eol}), 66'b111);
    chk("s3_early_data", 66'(dout), 66'h3001);
    realign();
    for (int i = 2; i < 6; i++) send(64'h3000 + 64'(i), 1'b0, 1'b0, 2'b01);
    idle();
    @(negedge clk);
    chk("s3_missing_pulse", 66'({e_miss, dout_vld, dout_eol}), 66'b111);
    chk("s3_missing_data", 66'(dout), 66'h3005);
    realign();
    for (int i = 6; i < 10; i++) send(64'h3000 + 64'(i), 1'b0, i == 9, 2'b01);
    idle();
    tick(4);
    chk("s3_count", 66'(q1.size() - s), 66'd10);
    for (int i = 0; i < 10; i++)
      if (s + i < q1.size())
        chk("s3_beat", q1[s + i], {i == 0, i == 1 || i == 5 || i == 9, 64'h3000 + 64'(i)});
    chk("s3_sticky", 66'(sticky), 66'b0011);
    chk("s3_err_counts", 66'({8'(n_early - b_e), 8'(n_miss - b_m), 8'(n_short - b_sh), 8'(n_orph - b_o)}),
        66'h01010000);
    chk("s3_frame_cnt", 66'(frame_cnt), 66'd3);

    // ---- 4: short frame ----
    s = q1.size(); b_e = n_early; b_m = n_miss; b_sh = n_short;
    for (int i = 0; i < 5; i++) send(64'h4000 + 64'(i), i == 0, i == 3, 2'b01);
    send(64'h4005, 1'b1, 1'b0, 2'b10);
    idle();
    @(negedge clk);
    chk("s4_short_pulse", 66'({e_short, frame_start, ftype_o}), 66'b1110);
    chk("s4_frame_cnt", 66'(frame_cnt), 66'd5);
    realign();
    for (int i = 1; i < 12; i++) send(64'h4005 + 64'(i), 1'b0, (i % 4) == 3, 2'b10);
    idle();
    tick(4);
    chk("s4_count", 66'(q1.size() - s), 66'd17);
    for (int j = 0; j < 17; j++)
      if (s + j < q1.size())
        chk("s4_beat", q1[s + j], {j == 0 || j == 5, j == 3 || (j >= 5 && ((j - 5) % 4) == 3),
                                  64'h4000 + 64'(j)});
    chk("s4_err_counts", 66'({8'(n_early - b_e), 8'(n_miss - b_m), 8'(n_short - b_sh)}), 66'h000001);
    chk("s4_sticky", 66'(sticky), 66'b0111);
    chk("s4_type", 66'(ftype_o), 66'b10);

    // ---- 5: orphans after reset ----
    rst_n = 1'b0;
    tick(1);
    reset_chk("s5_reset");
    realign();
    rst_n = 1'b1;
    tick(1);
    en2 = 1'b1;
    s = q1.size(); s2 = q2.size(); b_o = n_orph; b_o2 = n_orph2; b_v = n_vld;
    for (int i = 0; i < 3; i++) send(64'h5000 + 64'(i), 1'b0, i == 1, 2'b00);
    idle();
    en2 = 1'b0;
    tick(4);
    chk("s5_orphan_pulses", 66'(n_orph - b_o), 66'd3);
    chk("s5_orphan_pulses_fwd", 66'(n_orph2 - b_o2), 66'd3);
    chk("s5_drop_no_vld", 66'(n_vld - b_v), 66'd0);
    chk("s5_fwd_count", 66'(q2.size() - s2), 66'd3);
    for (int i = 0; i < 3; i++)
      if (s2 + i < q2.size())
        chk("s5_fwd_beat", q2[s2 + i], {2'b00, 64'h5000 + 64'(i)});
    chk("s5_sticky", 66'(sticky), 66'b1000);

    // ---- 6: sticky clear, clear vs set, reset mid-frame ----
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("s6_clr", 66'(sticky), 66'd0);
    realign();
    send(64'h6000, 1'b0, 1'b0, 2'b00);
    idle();
    err_clr = 1'b1;          // coincides with the orphan pulse
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("s6_set_wins", 66'(sticky), 66'b1000);
    realign();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("s6_clr_again", 66'(sticky), 66'd0);
    realign();

    s = q1.size();
    dout_rdy = 1'b0;
    send(64'h6100, 1'b1, 1'b0, 2'b11);
    send(64'h6101, 1'b0, 1'b0, 2'b11);
    idle();
    rst_n = 1'b0;
    tick(1);
    reset_chk("s6_reset");
    realign();
    rst_n = 1'b1;
    dout_rdy = 1'b1;
    tick(1);
    b_o = n_orph;
    send(64'h6200, 1'b0, 1'b0, 2'b00);
    idle();
    tick(4);
    chk("s6_post_reset_orphan", 66'(n_orph - b_o), 66'd1);
    chk("s6_buffer_discarded", 66'(q1.size() - s), 66'd0);
    chk("s6_frame_cnt", 66'(frame_cnt), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_frame_ingress.md
Name: axis_frame_ingress

Overview:
- Parametrised AXI4-Stream video ingress stage feeding the image preprocessing pipeline.
- Frames each incoming camera-link frame by SOF (tuser) and per-line EOL (tlast).
- Checks line and frame geometry against parameters and forwards beats to the local stream, tagged with corrected sof/eol markers.
- Supports true backpressure on both sides through a 2-entry skid buffer, and reports per-event error pulses, sticky error status and a frame counter.

Parameters:
- DATA_W, 64: stream data width in bits.
- PIX_W, 8: bits per pixel. DATA_W must be a multiple of PIX_W.
- IMG_W, 2048: pixels per line.
- IMG_H, 2048: lines per frame.
- DROP_ORPHAN, 1: 1 = discard beats received outside a frame; 0 = forward them with sof=0, eol=0.
- Derived (localparam): BPL = IMG_W*PIX_W/DATA_W, beats per line, integer, at least 2.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- s_axis_tdata, in, DATA_W: input data.
- s_axis_tvalid, in, 1: input valid.
- s_axis_tready, out, 1: input ready (registered).
- s_axis_tlast, in, 1: end of line.
- s_axis_tuser, in, 1: start of frame.
- frame_type_i, in, 2: frame type, sampled on the SOF beat.
- dout, out, DATA_W: output data.
- dout_vld, out, 1: output valid.
- dout_rdy, in, 1: downstream ready.
- dout_sof, out, 1: first beat of frame.
- dout_eol, out, 1: last beat of line (counter-derived).
- frame_start, out, 1: one-cycle pulse per accepted SOF.
- frame_type_o, out, 2: frame type latched at the last SOF.
- frame_cnt, out, 16: accepted SOF count, wraps at 16 bits.
- err_early_eol, out, 1: pulse, tlast seen before beat BPL-1.
- err_missing_eol, out, 1: pulse, beat BPL-1 arrived without tlast.
- err_short_frame, out, 1: pulse, SOF arrived while a frame was incomplete.
- err_orphan, out, 1: pulse, non-SOF beat arrived outside a frame.
- err_sticky, out, 4: {orphan, short_frame, missing_eol, early_eol}.
- err_clr, in, 1: clears err_sticky.

Behaviour:
- Accept is tvalid & tready. Only accepted beats affect state, counters or outputs.
- Reset values: every output is 0, including s_axis_tready. State = IDLE, beat_cnt = 0, line_cnt = 0, buffer empty. s_axis_tready rises the first cycle after rst_n=1. Reset mid-frame discards buffered beats and the frame in progress.
- Skid buffer (2 entries): s_axis_tready <= (next occupancy < 2). No beat is ever lost or duplicated under any tvalid/dout_rdy pattern. Latency is 1 cycle from the accepting edge to dout_vld when the buffer is empty. Data and flags are held stable while dout_vld & !dout_rdy.
- FSM states are IDLE (outside frame) and ACTIVE.
- Accepted beat with tuser=1, in any state:
  - Starts a new frame at beat 0, line 0; state -> ACTIVE.
  - Forwarded with dout_sof=1. frame_type_o <= frame_type_i; frame_start pulses; frame_cnt increments, 0xFFFF wraps to 0.
  - If the state was ACTIVE, err_short_frame pulses. This applies even at beat_cnt=0, line_cnt=0.
- Accepted beat in IDLE with tuser=0: err_orphan pulses. The beat is dropped if DROP_ORPHAN=1; otherwise it is forwarded with sof=eol=0. Counters are unchanged.
- Line end in ACTIVE occurs when tlast=1 or beat_cnt==BPL-1:
  - tlast=1 and beat_cnt<BPL-1: err_early_eol pulses.
  - beat_cnt==BPL-1 and tlast=0: err_missing_eol pulses.
  - On line end: dout_eol=1, beat_cnt <= 0, line_cnt increments.
  - Otherwise beat_cnt increments and dout_eol=0.
  - Line end when line_cnt==IMG_H-1 completes the frame: state -> IDLE and counters clear.
- A SOF beat that is also a line end gets dout_sof=1 and dout_eol=1. It counts as line 0, and the EOL checks are applied to beat_cnt=0.
- Timing of pulse outputs: frame_start and err_* pulses assert exactly the cycle after the accepting edge, for one cycle. Pulses are independent of downstream stalls.
- err_sticky bit i is set by the matching pulse and cleared by err_clr. Set wins when both occur in the same cycle.
- Widths: beat_cnt is clog2(BPL) bits; line_cnt is clog2(IMG_H) bits. Comparisons are exact; there is no saturation.

Test Plan:
(All scenarios use DATA_W=64, PIX_W=8, IMG_W=32, IMG_H=3, so BPL=4.)
1. Clean frame: SOF beat, then 12 beats with tlast on beats 3, 7, 11, dout_rdy=1 -> 12 outputs in order, 1-cycle latency; sof on beat 0; eol on beats 3, 7, 11; frame_cnt=1; no err pulses; state returns to IDLE.
2. Backpressure: same frame with dout_rdy toggling 1,0,0,1 and tvalid held high -> s_axis_tready drops when 2 entries are buffered; the output sequence is identical to scenario 1; no loss or duplication.
3. Line errors: tlast on beat 1 of line 0, and no tlast on beat 3 of line 1 -> err_early_eol pulse with eol on output beat 1; err_missing_eol pulse with eol forced on that beat; err_sticky=4'b0011.
4. Short frame: SOF, 5 beats, then a second SOF with frame_type_i=2'b10 -> err_short_frame pulse; frame_start pulse; frame_type_o=2'b10; frame_cnt=2; counters restart.
5. Orphans: 3 beats with tuser=0 after reset -> err_orphan pulses 3 times. With DROP_ORPHAN=1, dout_vld stays 0; with DROP_ORPHAN=0, 3 beats are output with sof=eol=0.
6. Sticky, clear and reset: err_clr asserted in the same cycle as an err_orphan pulse -> bit 3 stays set; err_clr alone -> err_sticky=0. rst_n=0 mid-frame -> all outputs 0 next cycle; after release, a non-SOF beat is flagged as orphan.
